// File: rtl/return_addr_stack_pkg.sv
// -----------------------------------------------------------------------------
// return_addr_stack_pkg
// Constants shared by the core's PC path and the return-address stack.
//   CORE_AW     : PC / address width of the 16-bit core
//   pc_sel_e    : next-PC selector encodings. The control unit and the RAS
//                 agree on the RET input code through PC_SEL_RET.
//   ras_cw()    : width needed to hold an occupancy count of 0..depth
// -----------------------------------------------------------------------------
package return_addr_stack_pkg;

    localparam int CORE_AW = 16;

    typedef enum logic [2:0] {
        PC_SEL_JMP  = 3'b000,
        PC_SEL_BR   = 3'b001,
        PC_SEL_RET  = 3'b010,
        PC_SEL_INC  = 3'b011,
        PC_SEL_LOOP = 3'b100
    } pc_sel_e;

    // Occupancy runs 0..depth inclusive, so one extra state beyond the index.
    function automatic int ras_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/return_addr_stack_if.sv
// -----------------------------------------------------------------------------
// return_addr_stack_if
// Control/status bundle between the pipeline and the return-address stack.
//   stall, push, push_addr, pop, clr_err  : driven by the pipeline (master)
//   ret_addr, empty, full, count,
//   overflow, underflow                   : driven by the stack (slave)
// -----------------------------------------------------------------------------
interface return_addr_stack_if
    import return_addr_stack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = CORE_AW
);
    localparam int CW = ras_cw(DEPTH);

    logic          stall;
    logic          push;
    logic [AW-1:0] push_addr;
    logic          pop;
    logic          clr_err;
    logic [AW-1:0] ret_addr;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    modport master (
        output stall, push, push_addr, pop, clr_err,
        input  ret_addr, empty, full, count, overflow, underflow
    );

    modport slave (
        input  stall, push, push_addr, pop, clr_err,
        output ret_addr, empty, full, count, overflow, underflow
    );

endinterface

// File: rtl/return_addr_stack_regfile.sv
// -----------------------------------------------------------------------------
// ras_regfile
// DEPTH x AW storage for the return-address stack. One write port, one
// combinational read port (the RET target must be available in the same cycle
// the RET is decoded). Contents are not reset; the top never exposes an entry
// that has not been written since reset.
//   clk      : core clock
//   wr_en    : write strobe
//   wr_idx   : entry to write
//   wr_data  : data to write
//   rd_idx   : entry to read
//   rd_data  : combinational read data
// -----------------------------------------------------------------------------
module ras_regfile #(
    parameter int DEPTH = 8,
    parameter int AW    = 16,
    parameter int IW    = 3
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [AW-1:0] wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [AW-1:0] rd_data
);

    logic [AW-1:0] mem [DEPTH];

    // One enable-gated register per entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (wr_en && (wr_idx == IW'(gi))) begin
                mem[gi] <= wr_data;
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
// Hardware return-address stack for the 16-bit core. CALL pushes PC+1, RET
// pops; the top entry drives the next-PC selector's RET input (PC_SEL_RET)
// with zero read latency. Overflow (push while full, push dropped) and
// underflow (pop while empty) are sticky until clr_err or reset.
//   clk    : core clock, rising-edge
//   reset  : synchronous, active-high; dominates everything
//   bus    : return_addr_stack_if.slave
//            in : stall, push, push_addr, pop, clr_err
//            out: ret_addr, empty, full, count, overflow, underflow
// DEPTH must be at least 2.
// -----------------------------------------------------------------------------
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = CORE_AW
) (
    input  logic                clk,
    input  logic                reset,
    return_addr_stack_if.slave  bus
);

    localparam int CW = ras_cw(DEPTH);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Stack pointer doubles as the occupancy count: top entry is mem[sp-1].
    logic [CW-1:0] sp_reg, sp_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;

    logic          push_eff, pop_eff;
    logic          is_empty, is_full;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;
    logic [AW-1:0] top_data;
    logic          ovf_event, unf_event;

    // A stalled pipeline neither pushes nor pops.
    assign push_eff = bus.push & ~bus.stall;
    assign pop_eff  = bus.pop  & ~bus.stall;

    assign is_empty = (sp_reg == '0);
    assign is_full  = (sp_reg == CW'(DEPTH));
    assign top_idx  = IW'(sp_reg - CW'(1));

    always_comb begin
        sp_next   = sp_reg;
        wr_en     = 1'b0;
        wr_idx    = IW'(sp_reg);
        ovf_event = 1'b0;
        unf_event = 1'b0;

        unique case ({push_eff, pop_eff})
            2'b10: begin
                if (is_full) begin
                    ovf_event = 1'b1;           // push dropped, no wrap
                end else begin
                    wr_en   = 1'b1;
                    sp_next = sp_reg + CW'(1);
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_event = 1'b1;
                end else begin
                    sp_next = sp_reg - CW'(1);
                end
            end
            2'b11: begin
                if (is_empty) begin
                    // Nothing to pop: the push still lands as entry 0.
                    wr_en     = 1'b1;
                    sp_next   = CW'(1);
                    unf_event = 1'b1;
                end else begin
                    // RET then CALL in one retire slot: overwrite the top.
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase

        // A new error in the same cycle as clr_err wins.
        overflow_next  = (overflow_reg  & ~bus.clr_err) | ovf_event;
        underflow_next = (underflow_reg & ~bus.clr_err) | unf_event;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_reg        <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            sp_reg        <= sp_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage writes are additionally gated by reset so reset truly
    // dominates a simultaneous push.
    ras_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (wr_en & ~reset),
        .wr_idx  (wr_idx),
        .wr_data (bus.push_addr),
        .rd_idx  (top_idx),
        .rd_data (top_data)
    );

    assign bus.ret_addr  = is_empty ? '0 : top_data;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.count     = sp_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;

endmodule

// File: tb/tb_return_addr_stack.sv
// -----------------------------------------------------------------------------
// tb_return_addr_stack
// Directed vector table (reset, push/pop order, full/overflow, empty/underflow,
// replace-top, stall, reset mid-push, clr_err vs. new-error priority) followed
// by randomized traffic compared against a queue-based model of the stack.
// -----------------------------------------------------------------------------
module tb_return_addr_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    return_addr_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    return_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        push;
        logic        pop;
        logic        clr;
        logic [15:0] addr;
        int          cnt;
        logic [15:0] ret;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [15:0] model_q[$];
    logic        m_ovf, m_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic stall, input logic push, input logic pop,
                       input logic clr, input logic [15:0] addr, input int cnt,
                       input logic [15:0] ret, input logic ovf, input logic unf);
        vec_t v;
        v.rst = rst; v.stall = stall; v.push = push; v.pop = pop; v.clr = clr;
        v.addr = addr; v.cnt = cnt; v.ret = ret; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic stall, input logic push, input logic pop,
                         input logic clr, input logic [15:0] addr);
        reset         = rst;
        bus.stall     = stall;
        bus.push      = push;
        bus.pop       = pop;
        bus.clr_err   = clr;
        bus.push_addr = addr;
    endtask

    task automatic check_state(input string tag, input int cnt, input logic [15:0] ret,
                               input logic ovf, input logic unf);
        check({tag, ".count"},     32'(bus.count),     32'(cnt));
        check({tag, ".ret_addr"},  32'(bus.ret_addr),  32'(ret));
        check({tag, ".empty"},     32'(bus.empty),     32'(cnt == 0));
        check({tag, ".full"},      32'(bus.full),      32'(cnt == DEPTH));
        check({tag, ".overflow"},  32'(bus.overflow),  32'(ovf));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(unf));
    endtask

    // Model: stack semantics expressed directly as queue operations.
    task automatic model_step(input logic rst, input logic stall, input logic push,
                              input logic pop, input logic clr, input logic [15:0] addr);
        logic p, q, ov, un;
        if (rst) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        p = push && !stall;
        q = pop && !stall;
        ov = 1'b0;
        un = 1'b0;
        if (p && !q) begin
            if (model_q.size() < DEPTH) model_q.push_back(addr);
            else ov = 1'b1;
        end else if (!p && q) begin
            if (model_q.size() > 0) void'(model_q.pop_back());
            else un = 1'b1;
        end else if (p && q) begin
            if (model_q.size() > 0) model_q[model_q.size()-1] = addr;
            else begin
                model_q.push_back(addr);
                un = 1'b1;
            end
        end
        m_ovf = (m_ovf && !clr) || ov;
        m_unf = (m_unf && !clr) || un;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        //   rst stl psh pop clr addr      cnt ret       ovf  unf
        add(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);   // reset
        add(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);   // idle
        add(0, 0, 1, 0, 0, 16'h0011, 1, 16'h0011, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0022, 2, 16'h0022, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0033, 3, 16'h0033, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0000, 2, 16'h0022, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0000, 1, 16'h0011, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            add(0, 0, 1, 0, 0, 16'h0100 + 16'(i), i + 1, 16'h0100 + 16'(i), 0, 0);
        add(0, 0, 1, 0, 0, 16'h0BAD, 8, 16'h0107, 1, 0);   // dropped push
        add(0, 0, 0, 0, 1, 16'h0000, 8, 16'h0107, 0, 0);   // clr_err
        add(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1);   // pop while empty
        add(0, 0, 1, 1, 0, 16'h0042, 1, 16'h0042, 0, 1);   // push+pop on empty
        add(0, 0, 0, 0, 1, 16'h0000, 1, 16'h0042, 0, 0);
        add(1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0010, 1, 16'h0010, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0020, 2, 16'h0020, 0, 0);
        add(0, 0, 1, 1, 0, 16'h0055, 2, 16'h0055, 0, 0);   // replace top
        add(0, 0, 0, 1, 0, 16'h0000, 1, 16'h0010, 0, 0);
        add(0, 1, 1, 0, 0, 16'h0001, 1, 16'h0010, 0, 0);   // stalled push
        add(0, 0, 1, 0, 0, 16'h0030, 2, 16'h0030, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0040, 3, 16'h0040, 0, 0);
        add(1, 0, 1, 0, 0, 16'h0002, 0, 16'h0000, 0, 0);   // reset beats push
        add(0, 1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0);   // stalled pop: no flag
        add(0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1);
        add(0, 1, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0);   // clr_err under stall
        add(0, 0, 0, 1, 1, 16'h0000, 0, 16'h0000, 0, 1);   // set beats clear
        add(0, 0, 1, 0, 0, 16'h0077, 1, 16'h0077, 0, 1);   // write after reset visible
        add(0, 1, 1, 1, 0, 16'h0088, 1, 16'h0077, 0, 1);   // stalled push+pop

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].push, vecs[i].pop,
                  vecs[i].clr, vecs[i].addr);
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ret,
                        vecs[i].ovf, vecs[i].unf);
        end

        // Randomized traffic against the queue model
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_stl, r_psh, r_pop, r_clr;
            logic [15:0] r_addr;
            logic [15:0] exp_ret;
            r_rst  = ($urandom_range(0, 99) < 2);
            r_stl  = ($urandom_range(0, 99) < 15);
            r_psh  = ($urandom_range(0, 99) < 55);
            r_pop  = ($urandom_range(0, 99) < 45);
            r_clr  = ($urandom_range(0, 99) < 10);
            r_addr = 16'($urandom);
            drive(r_rst, r_stl, r_psh, r_pop, r_clr, r_addr);
            model_step(r_rst, r_stl, r_psh, r_pop, r_clr, r_addr);
            @(posedge clk);
            #1;
            exp_ret = (model_q.size() > 0) ? model_q[model_q.size()-1] : 16'h0000;
            check_state($sformatf("rand%0d", i), model_q.size(), exp_ret, m_ovf, m_unf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
Hardware return-address stack (RAS) for the 16-bit core's PC path. It captures the return address (PC+1) on CALL and supplies the saved address on RET. It drives the next-PC selector's RET input (select code 3'b010) directly. On overflow or underflow it raises sticky error flags so the control unit can trap.

Parameters:
DEPTH, 8, number of 16-bit entries; must be ≥2.
AW, 16, address width; matches the PC width.
CW, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
clk  in  1  core clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  pipeline hold; when 1, push and pop are ignored and all state holds.
push  in  1  CALL retiring this cycle.
push_addr  in  AW  return address to save (PC+1 from the PC adder).
pop  in  1  RET retiring this cycle.
clr_err  in  1  clears the sticky overflow/underflow flags.
ret_addr  out  AW  current top entry; feeds next-PC selector input 2.
empty  out  1  count == 0.
full  out  1  count == DEPTH.
count  out  CW  current occupancy.
overflow  out  1  sticky: a push was dropped because the stack was full.
underflow  out  1  sticky: a pop was issued while the stack was empty.

Behaviour:
- Single clock, synchronous active-high reset. Reset dominates every other input, including mid-sequence pushes and pops. On reset: count=0, empty=1, full=0, overflow=0, underflow=0, ret_addr=16'h0000. Storage contents are don't-care after reset but never visible.
- Storage: DEPTH×AW register array plus a stack pointer sp (0..DEPTH); sp equals count. The top entry is mem[sp-1].
- ret_addr is combinational from registered state: mem[sp-1] when count>0, else 16'h0000. There is zero-cycle read latency, so a RET decoded this cycle sees the correct target this cycle. The pop takes effect at the next edge.
- Effective ops: p = push & ~stall; q = pop & ~stall.
- p=1, q=0:
  - If not full: write mem[sp]=push_addr, then sp+1.
  - If full: drop the push, state unchanged, set overflow.
- p=0, q=1:
  - If not empty: sp-1.
  - If empty: no change, set underflow.
- p=1, q=1 (RET followed by CALL in the same retire slot):
  - If not empty: replace the top, mem[sp-1]=push_addr; count unchanged; no flag.
  - If empty: treat as a plain push (count becomes 1) and set underflow.
- p=0, q=0: hold.
- stall=1: no state change at all, including flags. clr_err still acts.
- clr_err=1 clears overflow and underflow at the edge. If a new error event occurs in the same cycle, set wins.
- Flags stay set until clr_err or reset.
- No wrap-around: pushes never overwrite the oldest entry, and sp never leaves the range [0, DEPTH].
- One-cycle write latency: data pushed at edge N appears on ret_addr after edge N.

Decomposition:
- Shared package (core pkg): AW=16 and the PC-select encodings (PC_SEL_JMP=3'b000, PC_SEL_BR=3'b001, PC_SEL_RET=3'b010, PC_SEL_INC=3'b011, PC_SEL_LOOP=3'b100). The control unit and this block agree on the RET code through these constants.
- No sub-module required. If one is split out, make it ras_regfile: a DEPTH×AW array with one write port and a combinational read. Pointer and flag logic stay in the top.

Test Plan:
1. Reset, then idle -> count=0, empty=1, ret_addr=16'h0000, overflow=0, underflow=0.
2. Push 16'h0011, 16'h0022, 16'h0033 on consecutive cycles -> ret_addr=16'h0033, count=3. Then pop ×3 -> ret_addr reads 0x0033, 0x0022, 0x0011 before each edge; ends empty with ret_addr=0.
3. DEPTH=8: push 0x0100..0x0107, then push 0x0BAD -> full=1, count=8, ret_addr=0x0107, overflow=1. clr_err pulse -> overflow=0.
4. Pop while empty -> underflow=1, count stays 0. Then push+pop together with push_addr=0x0042 -> count=1, ret_addr=0x0042.
5. Stack holds 0x0010 and 0x0020; assert push+pop with push_addr=0x0055 -> count=2, ret_addr=0x0055. Then pop -> ret_addr=0x0010.
6. Push 0x0001 with stall=1 -> no change. Reset asserted during a push of 0x0002 with count=3 -> next cycle count=0, ret_addr=0, flags clear.
